// File: rtl/wb_sram_banked_ctrl.sv
// Wishbone classic slave fronting N_BANKS single-port 32-bit SRAM macros.
// Ports: wb_clk_i/wb_rst_i clock and async reset; wbs_* Wishbone slave
//   (cyc, stb, we, sel, adr, dat in; ack, dat out); sram_* shared macro
//   bus with one-hot sram_en_o and concatenated per-bank sram_dout_i.
module wb_sram_banked_ctrl #(
  parameter int          N_BANKS   = 4,
  parameter int          BANK_AW   = 12,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_0000,
  parameter int          RD_LAT    = 1
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic [N_BANKS-1:0]    sram_en_o,
  output logic                  sram_we_o,
  output logic [31:0]           sram_ben_o,
  output logic [BANK_AW-1:0]    sram_addr_o,
  output logic [31:0]           sram_din_o,
  input  logic [N_BANKS*32-1:0] sram_dout_i
);
  localparam int BW = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;

  typedef enum logic [1:0] {IDLE, ACC, WAIT, ACK} state_t;

  state_t             r_state;
  logic [BW-1:0]      r_bank;
  logic               r_we;
  logic               r_miss;
  logic [1:0]         r_cnt;
  logic               r_ack;
  logic [31:0]        r_dat;
  logic [N_BANKS-1:0] r_en;
  logic               r_swe;
  logic [31:0]        r_ben;
  logic [BANK_AW-1:0] r_addr;
  logic [31:0]        r_din;

  logic [BANK_AW-1:0] w_word;
  logic [BW-1:0]      w_bank;
  logic               w_hit;
  logic               w_go;
  logic               w_req;
  logic [N_BANKS-1:0] w_onehot;
  logic [31:0]        w_ben;
  logic [31:0]        w_rdata;

  assign w_word = wbs_adr_i[BANK_AW+1:2];
  assign w_bank = (N_BANKS > 1) ? wbs_adr_i[BANK_AW+2 +: BW] : '0;
  assign w_hit  = ((wbs_adr_i & ADDR_MASK) == (BASE_ADDR & ADDR_MASK))
               && (int'(w_bank) < N_BANKS);
  // A write with no byte lanes is acked without touching a macro.
  assign w_go   = w_hit & ~(wbs_we_i & (wbs_sel_i == 4'h0));
  // The ack cycle itself is not a sampling point: a held stb must
  // not start a second access before the master has seen the ack.
  assign w_req  = wbs_cyc_i & wbs_stb_i & ~r_ack;

  always_comb begin
    w_onehot = '0;
    for (int b = 0; b < N_BANKS; b++)
      if (int'(w_bank) == b) w_onehot[b] = 1'b1;
  end

  always_comb begin
    w_rdata = '0;
    for (int b = 0; b < N_BANKS; b++)
      if (int'(r_bank) == b) w_rdata = sram_dout_i[32*b +: 32];
  end

  always_comb begin
    w_ben = '0;
    for (int i = 0; i < 4; i++) w_ben[8*i +: 8] = {8{wbs_sel_i[i]}};
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
      r_bank  <= '0;
      r_we    <= 1'b0;
      r_miss  <= 1'b0;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      r_dat   <= '0;
      r_en    <= '0;
      r_swe   <= 1'b0;
      r_ben   <= '0;
      r_addr  <= '0;
      r_din   <= '0;
    end else begin
      r_ack <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_req) begin
            r_bank <= w_bank;
            r_we   <= wbs_we_i;
            r_miss <= ~w_hit;
            if (w_go) begin
              r_state <= ACC;
              r_en    <= w_onehot;
              r_swe   <= wbs_we_i;
              r_ben   <= wbs_we_i ? w_ben : '0;
              r_addr  <= w_word;
              r_din   <= wbs_dat_i;
            end else begin
              r_state <= ACK;
            end
          end
        end
        ACC: begin
          r_en   <= '0;
          r_swe  <= 1'b0;
          r_ben  <= '0;
          r_addr <= '0;
          r_din  <= '0;
          r_cnt  <= '0;
          if (!wbs_cyc_i)                r_state <= IDLE;
          else if (r_we || RD_LAT <= 1)  r_state <= ACK;
          else                           r_state <= WAIT;
        end
        WAIT: begin
          if (!wbs_cyc_i)                     r_state <= IDLE;
          else if (r_cnt == 2'(RD_LAT - 2))   r_state <= ACK;
          else                                r_cnt   <= r_cnt + 2'd1;
        end
        ACK: begin
          r_state <= IDLE;
          if (wbs_cyc_i) begin
            r_ack <= 1'b1;
            if (!r_we) r_dat <= r_miss ? 32'h0 : w_rdata;
          end
        end
      endcase
    end
  end

  assign wbs_ack_o   = r_ack;
  assign wbs_dat_o   = r_dat;
  assign sram_en_o   = r_en;
  assign sram_we_o   = r_swe;
  assign sram_ben_o  = r_ben;
  assign sram_addr_o = r_addr;
  assign sram_din_o  = r_din;
endmodule
